// File: rtl/m2_fwd_pkg.sv
// Shared defaults and helpers for the m2 forward buffer.
// Optional build macro: M2_FWD_OUTREG_EN (adds a second read-output register stage).
package m2_fwd_pkg;

  localparam int M2_N_DEF         = 16;
  localparam int M2_TN_DEF        = 16;
  localparam int M2_ADDR_DEF      = 2;
  localparam int M2_NUM_WORDS_DEF = 4;
  localparam int M2_WORD_W_DEF    = M2_TN_DEF * M2_N_DEF;

  // Occupancy counter width: must hold 0..num_words inclusive.
  function automatic int cw_f(input int num_words);
    return $clog2(num_words + 1);
  endfunction

  // Low bit of a lane's slice inside a lane-concatenated bus.
  function automatic int lane_lo(input int lane, input int slice_w);
    return lane * slice_w;
  endfunction

endpackage

// File: rtl/m2_fwd_lane.sv
// One lane of the m2 forward buffer: word storage, per-entry valid bits,
// occupancy counter and the registered read path.
// Optional build macro: M2_FWD_OUTREG_EN (second read-output stage, latency 2).
module m2_fwd_lane
  import m2_fwd_pkg::*;
#(
  parameter int N         = M2_N_DEF,
  parameter int TN        = M2_TN_DEF,
  parameter int ADDR      = M2_ADDR_DEF,
  parameter int NUM_WORDS = M2_NUM_WORDS_DEF,
  localparam int W        = TN * N,
  localparam int CW       = cw_f(NUM_WORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    i_data,
  input  logic [ADDR-1:0] i_wr_addr,
  input  logic            i_wen,
  input  logic [ADDR-1:0] i_rd_addr,
  input  logic            i_ren,
  input  logic            i_consume,
  input  logic            i_flush,
  output logic [W-1:0]    o_data,
  output logic            o_rd_valid,
  output logic            o_rd_hit,
  output logic [CW-1:0]   o_count,
  output logic            o_full,
  output logic            o_empty
);

  logic [W-1:0]         mem_q [NUM_WORDS];
  logic [NUM_WORDS-1:0] valid_q, valid_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, empty_q;
  logic [W-1:0]         rd_data_q, rd_data_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 rd_hit_q, rd_hit_d;
  logic                 wr_ok, rd_ok, rd_coll;

  // Next-state for read result, valid bits and occupancy (write-first, flush wins).
  always_comb begin
    wr_ok    = i_wen && (int'(i_wr_addr) < NUM_WORDS);
    rd_ok    = i_ren && (int'(i_rd_addr) < NUM_WORDS);
    rd_coll  = wr_ok && rd_ok && (i_wr_addr == i_rd_addr);
    rd_vld_d = i_ren;
    rd_hit_d = 1'b0;
    rd_data_d = rd_data_q;
    if (i_ren) begin
      rd_hit_d = rd_coll || (rd_ok && valid_q[i_rd_addr]);
      if (rd_coll)       rd_data_d = i_data;
      else if (rd_hit_d) rd_data_d = mem_q[i_rd_addr];
      else               rd_data_d = '0;
    end
    valid_d = valid_q;
    if (rd_ok && i_consume) valid_d[i_rd_addr] = 1'b0;
    if (wr_ok)              valid_d[i_wr_addr] = 1'b1;
    if (i_flush)            valid_d = '0;
    count_d = '0;
    for (int k = 0; k < NUM_WORDS; k++) count_d = count_d + CW'(valid_d[k]);
  end

  // Storage array; deliberately not reset, a flush in the same cycle drops the write.
  always_ff @(posedge clk) begin
    if (wr_ok && !i_flush) mem_q[i_wr_addr] <= i_data;
  end

  // Control state and first read-output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_hit_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      full_q    <= (count_d == CW'(NUM_WORDS));
      empty_q   <= (count_d == '0);
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      rd_hit_q  <= rd_hit_d;
    end
  end

`ifdef M2_FWD_OUTREG_EN
  logic [W-1:0] rd_data2_q;
  logic         rd_vld2_q;
  logic         rd_hit2_q;

  // Extra output stage for timing closure toward the NFU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data2_q <= '0;
      rd_vld2_q  <= 1'b0;
      rd_hit2_q  <= 1'b0;
    end else begin
      rd_data2_q <= rd_data_q;
      rd_vld2_q  <= rd_vld_q;
      rd_hit2_q  <= rd_hit_q;
    end
  end

  assign o_data     = rd_data2_q;
  assign o_rd_valid = rd_vld2_q;
  assign o_rd_hit   = rd_hit2_q;
`else
  assign o_data     = rd_data_q;
  assign o_rd_valid = rd_vld_q;
  assign o_rd_hit   = rd_hit_q;
`endif

  assign o_count = count_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/m2_fwd_buffer.sv
// Tn-lane forward buffer between the neuron-input fetch stage and the NFU.
// Lanes are independent; only i_flush is shared.
// Optional build macro: M2_FWD_OUTREG_EN (read latency 2 instead of 1).
module m2_fwd_buffer
  import m2_fwd_pkg::*;
#(
  parameter int N         = M2_N_DEF,
  parameter int Tn        = M2_TN_DEF,
  parameter int ADDR      = M2_ADDR_DEF,
  parameter int NUM_WORDS = M2_NUM_WORDS_DEF,
  localparam int CW       = cw_f(NUM_WORDS),
  localparam int WORD_W   = Tn * N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*Tn*Tn-1:0]   i_data,
  input  logic [ADDR*Tn-1:0]   i_wr_addr,
  input  logic [Tn-1:0]        i_wen,
  input  logic [ADDR*Tn-1:0]   i_rd_addr,
  input  logic [Tn-1:0]        i_ren,
  input  logic [Tn-1:0]        i_consume,
  input  logic                 i_flush,
  output logic [N*Tn*Tn-1:0]   o_data,
  output logic [Tn-1:0]        o_rd_valid,
  output logic [Tn-1:0]        o_rd_hit,
  output logic [CW*Tn-1:0]     o_count,
  output logic [Tn-1:0]        o_full,
  output logic [Tn-1:0]        o_empty
);

  for (genvar g = 0; g < Tn; g++) begin : g_lane
    m2_fwd_lane #(
      .N         (N),
      .TN        (Tn),
      .ADDR      (ADDR),
      .NUM_WORDS (NUM_WORDS)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_data     (i_data[lane_lo(g, WORD_W) +: WORD_W]),
      .i_wr_addr  (i_wr_addr[lane_lo(g, ADDR) +: ADDR]),
      .i_wen      (i_wen[g]),
      .i_rd_addr  (i_rd_addr[lane_lo(g, ADDR) +: ADDR]),
      .i_ren      (i_ren[g]),
      .i_consume  (i_consume[g]),
      .i_flush    (i_flush),
      .o_data     (o_data[lane_lo(g, WORD_W) +: WORD_W]),
      .o_rd_valid (o_rd_valid[g]),
      .o_rd_hit   (o_rd_hit[g]),
      .o_count    (o_count[lane_lo(g, CW) +: CW]),
      .o_full     (o_full[g]),
      .o_empty    (o_empty[g])
    );
  end

endmodule

// File: tb/tb_m2_fwd_buffer.sv
// Self-checking bench for m2_fwd_buffer: directed scenarios plus random traffic
// against a per-lane behavioural model of the buffer contents.
module tb_m2_fwd_buffer;

  localparam int N  = 16;
  localparam int TN = 16;
  localparam int AW = 2;
  localparam int NW = 4;
  localparam int CW = 3;
  localparam int WW = TN * N;
`ifdef M2_FWD_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*TN*TN-1:0] i_data;
  logic [AW*TN-1:0]   i_wr_addr, i_rd_addr;
  logic [TN-1:0]      i_wen, i_ren, i_consume;
  logic               i_flush;
  logic [N*TN*TN-1:0] o_data;
  logic [TN-1:0]      o_rd_valid, o_rd_hit, o_full, o_empty;
  logic [CW*TN-1:0]   o_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: stored words and valid flags, plus expected read outputs
  logic [WW-1:0] m_mem [TN][NW];
  bit            m_val [TN][NW];
  logic [WW-1:0] e1_data [TN];
  bit            e1_vld [TN], e1_hit [TN];
  logic [WW-1:0] e2_data [TN];
  bit            e2_vld [TN], e2_hit [TN];

  m2_fwd_buffer dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_wr_addr(i_wr_addr),
    .i_wen(i_wen), .i_rd_addr(i_rd_addr), .i_ren(i_ren), .i_consume(i_consume),
    .i_flush(i_flush), .o_data(o_data), .o_rd_valid(o_rd_valid),
    .o_rd_hit(o_rd_hit), .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lane_count(input int l);
    int c = 0;
    for (int k = 0; k < NW; k++) c += m_val[l][k] ? 1 : 0;
    return c;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < TN; l++) begin
      for (int k = 0; k < NW; k++) m_val[l][k] = 0;
      e1_data[l] = '0; e1_vld[l] = 0; e1_hit[l] = 0;
      e2_data[l] = '0; e2_vld[l] = 0; e2_hit[l] = 0;
    end
  endtask

  task automatic clr_in();
    i_data = '0; i_wr_addr = '0; i_rd_addr = '0;
    i_wen = '0; i_ren = '0; i_consume = '0; i_flush = 1'b0;
  endtask

  task automatic set_lane(input int l, input bit wen, input int wa, input bit ren,
                          input int ra, input bit cons, input logic [WW-1:0] d);
    logic [31:0] wav, rav;
    wav = wa; rav = ra;
    i_wen[l] = wen; i_ren[l] = ren; i_consume[l] = cons;
    i_wr_addr[l*AW +: AW] = wav[AW-1:0];
    i_rd_addr[l*AW +: AW] = rav[AW-1:0];
    i_data[l*WW +: WW] = d;
  endtask

  task automatic check_all();
    logic [WW-1:0] ev, eh, ef, ee, ec;
    ev = '0; eh = '0; ef = '0; ee = '0; ec = '0;
    for (int l = 0; l < TN; l++) begin
      int c;
      logic [31:0] cv;
      c = lane_count(l);
      cv = c;
      ec[l*CW +: CW] = cv[CW-1:0];
      ef[l] = (c == NW);
      ee[l] = (c == 0);
`ifdef M2_FWD_OUTREG_EN
      ev[l] = e2_vld[l]; eh[l] = e2_hit[l];
      check($sformatf("data_l%0d", l), o_data[l*WW +: WW], e2_data[l]);
`else
      ev[l] = e1_vld[l]; eh[l] = e1_hit[l];
      check($sformatf("data_l%0d", l), o_data[l*WW +: WW], e1_data[l]);
`endif
    end
    check("rd_valid", WW'(o_rd_valid), ev);
    check("rd_hit", WW'(o_rd_hit), eh);
    check("count", WW'(o_count), ec);
    check("full", WW'(o_full), ef);
    check("empty", WW'(o_empty), ee);
  endtask

  // One clock: model computes results from pre-edge state, then state advances.
  task automatic step();
    logic [WW-1:0] nd [TN];
    bit nv [TN], nh [TN];
    bit fl;
    int wa [TN], ra [TN];
    bit we [TN], re [TN], co [TN];
    logic [WW-1:0] wd [TN];
    fl = i_flush;
    for (int l = 0; l < TN; l++) begin
      we[l] = i_wen[l]; re[l] = i_ren[l]; co[l] = i_consume[l];
      wa[l] = int'(i_wr_addr[l*AW +: AW]); ra[l] = int'(i_rd_addr[l*AW +: AW]);
      wd[l] = i_data[l*WW +: WW];
      if (re[l]) begin
        bit coll, rin;
        rin  = ra[l] < NW;
        coll = we[l] && (wa[l] < NW) && rin && (wa[l] == ra[l]);
        nv[l] = 1;
        nh[l] = coll || (rin && m_val[l][ra[l]]);
        nd[l] = coll ? wd[l] : (nh[l] ? m_mem[l][ra[l]] : '0);
      end else begin
        nv[l] = 0; nh[l] = 0; nd[l] = e1_data[l];
      end
    end
    @(posedge clk);
    for (int l = 0; l < TN; l++) begin
      e2_data[l] = e1_data[l]; e2_vld[l] = e1_vld[l]; e2_hit[l] = e1_hit[l];
      e1_data[l] = nd[l]; e1_vld[l] = nv[l]; e1_hit[l] = nh[l];
      if (re[l] && co[l] && ra[l] < NW) m_val[l][ra[l]] = 0;
      if (we[l] && wa[l] < NW) begin
        m_mem[l][wa[l]] = wd[l];
        m_val[l][wa[l]] = 1;
      end
      if (fl) for (int k = 0; k < NW; k++) m_val[l][k] = 0;
    end
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    clr_in();
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    logic [WW-1:0] pat, x;
    pat = {(WW/16){16'hA5A5}};
    clr_in();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all();
    check("rst_empty", WW'(o_empty), WW'({TN{1'b1}}));
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back lane 0 addr 2
    clr_in(); set_lane(0, 1, 2, 0, 0, 0, pat); step();
    clr_in(); set_lane(0, 0, 0, 1, 2, 0, '0); step();
    idle(LAT - 1);
    check("t1_vld", WW'(o_rd_valid[0]), WW'(1));
    check("t1_hit", WW'(o_rd_hit[0]), WW'(1));
    check("t1_data", o_data[0 +: WW], pat);
    check("t1_count", WW'(o_count[0 +: CW]), WW'(1));

    // Unwritten entry on lane 3
    clr_in(); set_lane(3, 0, 0, 1, 1, 0, '0); step();
    idle(LAT - 1);
    check("t2_vld", WW'(o_rd_valid[3]), WW'(1));
    check("t2_hit", WW'(o_rd_hit[3]), WW'(0));
    check("t2_data", o_data[3*WW +: WW], '0);
    check("t2_empty", WW'(o_empty[3]), WW'(1));

    // Same-cycle write/read on lane 5
    x = rnd_word();
    clr_in(); set_lane(5, 1, 0, 1, 0, 0, x); step();
    idle(LAT - 1);
    check("t3_hit", WW'(o_rd_hit[5]), WW'(1));
    check("t3_data", o_data[5*WW +: WW], x);

    // Fill lane 1, consume one entry, re-read it
    for (int a = 0; a < NW; a++) begin
      clr_in(); set_lane(1, 1, a, 0, 0, 0, rnd_word()); step();
    end
    check("t4_full", WW'(o_full[1]), WW'(1));
    check("t4_cnt4", WW'(o_count[1*CW +: CW]), WW'(4));
    clr_in(); set_lane(1, 0, 0, 1, 2, 1, '0); step();
    check("t4_cnt3", WW'(o_count[1*CW +: CW]), WW'(3));
    check("t4_nfull", WW'(o_full[1]), WW'(0));
    clr_in(); set_lane(1, 0, 0, 1, 2, 0, '0); step();
    idle(LAT - 1);
    check("t4_rehit", WW'(o_rd_hit[1]), WW'(0));

    // Write and consume same entry on lane 2, then flush
    clr_in(); set_lane(2, 1, 1, 0, 0, 0, rnd_word()); step();
    clr_in(); set_lane(2, 1, 1, 1, 1, 1, rnd_word()); step();
    check("t5_cnt", WW'(o_count[2*CW +: CW]), WW'(1));
    clr_in(); i_flush = 1'b1; step();
    check("t5_flcnt", WW'(o_count), '0);
    check("t5_flempty", WW'(o_empty), WW'({TN{1'b1}}));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      clr_in();
      for (int l = 0; l < TN; l++) begin
        bit r;
        r = ($urandom_range(0, 1) == 1);
        set_lane(l, $urandom_range(0, 2) != 0, $urandom_range(0, NW - 1), r,
                 $urandom_range(0, NW - 1), r && ($urandom_range(0, 2) == 0), rnd_word());
      end
      i_flush = ($urandom_range(0, 39) == 0);
      step();
    end

    // Reset while reads are in flight
    clr_in();
    for (int l = 0; l < TN; l++) set_lane(l, 0, 0, 1, $urandom_range(0, NW - 1), 0, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_vld_now", WW'(o_rd_valid), '0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_in();
    model_reset();
    @(posedge clk);
    #1;
    check("rst_vld_after", WW'(o_rd_valid), '0);
    check("rst_count", WW'(o_count), '0);
    @(negedge clk);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m2_fwd_buffer.md
Name: m2_fwd_buffer

Overview:
- Parametrised successor of the per-lane forward buffer. Tn independent lanes; each lane stores NUM_WORDS words of Tn*N bits.
- Adds to the prior buffer:
  - per-entry valid tracking;
  - read-enable with registered output and a valid strobe;
  - consume-on-read, with occupancy and full/empty flags per lane;
  - write-first forwarding on a same-address read/write collision.
- Sits between the neuron-input fetch stage and the NFU, holding reusable input tiles.

Parameters:
- N, 16, bits per element.
- Tn, 16, lane count; also elements per word.
- ADDR, 2, address bits per lane.
- NUM_WORDS, 4, words per lane. Legal range is 1 to 2**ADDR.
- CW, $clog2(NUM_WORDS+1), occupancy counter width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- i_data  in  N*Tn*Tn  write data; lane i uses slice [(i+1)*Tn*N-1 : i*Tn*N]
- i_wr_addr  in  ADDR*Tn  per-lane write address
- i_wen  in  Tn  per-lane write enable
- i_rd_addr  in  ADDR*Tn  per-lane read address
- i_ren  in  Tn  per-lane read enable
- i_consume  in  Tn  per-lane: clear the valid bit of the entry read this cycle; qualified by i_ren
- i_flush  in  1  synchronous clear of all valid bits in all lanes
- o_data  out  N*Tn*Tn  per-lane read data
- o_rd_valid  out  Tn  read-data strobe
- o_rd_hit  out  Tn  the entry read was valid
- o_count  out  CW*Tn  per-lane valid-entry count
- o_full  out  Tn  count == NUM_WORDS
- o_empty  out  Tn  count == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - all valid bits, o_data, o_rd_valid, o_rd_hit and o_count go to 0;
  - o_empty goes to all ones, o_full to all zeros;
  - the storage array is not reset.
- Reset mid-operation: all in-flight reads are discarded. No o_rd_valid is produced for a read issued in the cycle of, or the cycle before, reset assertion.
- Lanes are fully independent; no cross-lane interaction except i_flush.
- Write: on a rising edge with i_wen[i], mem[i][i_wr_addr] takes the lane data and its valid bit is set.
  - Rewriting an entry that is already valid does not change the count.
- Read: on a rising edge with i_ren[i]:
  - o_data lane, o_rd_valid[i] and o_rd_hit[i] are registered, so latency is 1 cycle;
  - o_rd_valid[i] = 1 for every issued read;
  - o_rd_hit[i] = the entry's valid bit;
  - data = stored word if hit, else all zeros.
- With i_ren[i] low, o_rd_valid[i] = 0, o_rd_hit[i] = 0, and the o_data lane holds its last value.
- Write/read collision (same lane, same address, same cycle):
  - write-first; the read returns the new i_data with o_rd_hit = 1.
- Consume:
  - i_ren & i_consume clears the entry's valid bit after the read samples it; the count decrements if the entry was valid.
  - i_consume without i_ren is ignored.
- Write and consume to the same address in the same cycle: the write wins. The entry ends valid and the count is unchanged net.
- Write and consume to different addresses in the same cycle: both take effect; the count changes by +1 or -1 only where a valid bit actually changes.
- Out-of-range address (at or above NUM_WORDS):
  - write is dropped;
  - read returns o_rd_valid = 1, o_rd_hit = 0, zero data;
  - consume is a no-op.
- Full: a write to an invalid entry when the lane is full cannot occur by construction. o_full is advisory, and writes are never blocked.
- i_flush:
  - clears every valid bit and count next edge;
  - reads in that cycle still sample the pre-flush state;
  - writes in that cycle are lost (flush wins).
- o_count, o_full and o_empty are registered and reflect state after the edge.

Optional Feature:
- M2_FWD_OUTREG_EN defined:
  - adds a second register stage on o_data, o_rd_valid and o_rd_hit, making read latency 2 cycles;
  - the extra stage resets to 0;
  - occupancy outputs are unaffected.
- Undefined: read latency is 1 cycle as above.

Decomposition:
- Package m2_fwd_pkg holds:
  - default N/Tn/ADDR/NUM_WORDS;
  - lane word width (Tn*N);
  - the CW derivation function;
  - slice-offset helper constants.
- One sub-module, m2_fwd_lane, holds one lane's storage, valid bits, counter and read pipeline.
- The top instantiates Tn copies in a generate loop and fans out i_flush.

Test Plan:
- Reset, then write lane 0 addr 2 with 0xA5A5-pattern; read addr 2 next cycle -> 1 cycle later o_rd_valid[0]=1, o_rd_hit[0]=1, data=pattern; o_count[0]=1.
- Read lane 3 addr 1 never written -> o_rd_valid[3]=1, o_rd_hit[3]=0, data=0; o_empty[3]=1.
- Same cycle: write lane 5 addr 0 value X, read addr 0 -> returned data=X, hit=1 (write-first).
- Fill lane 1 addrs 0..3 -> o_full[1]=1, count=4; read+consume addr 2 -> count=3, o_full[1]=0; re-read addr 2 -> hit=0.
- Write+consume lane 2 addr 1 in same cycle on a valid entry -> entry stays valid, count unchanged; then i_flush -> all counts 0, all o_empty=1.
- Assert rst_n low for half a cycle while a read is in flight -> o_rd_valid is 0 immediately and stays 0 after release. With M2_FWD_OUTREG_EN defined, rerun the first scenario and confirm latency is 2.
